// File: rtl/serial_equality_checker_pkg.sv
// Shared types and constants for the serial equality checker.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_equality_checker_pkg;

   // Operand width shared with the parallel 4-bit equality comparator.
   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_equality_checker_equality_bit_cell.sv
// One-bit equality cell: match_out = match_in & ~(a_bit ^ b_bit), built from gate primitives.
// Latency: combinational, zero cycles.
// Backpressure: none; pure logic.
// Ports: a_bit/b_bit operand bits, match_in running match, match_out updated match.

module xnorgate (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = ~(a ^ b);
endmodule

module andgate (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a & b;
endmodule

module equality_bit_cell (
   input  logic a_bit,
   input  logic b_bit,
   input  logic match_in,
   output logic match_out
);
   logic bit_eq;

   xnorgate u_xnor (
      .a (a_bit),
      .b (b_bit),
      .y (bit_eq)
   );

   andgate u_and (
      .a (bit_eq),
      .b (match_in),
      .y (match_out)
   );
endmodule

// File: rtl/serial_equality_checker.sv
// Bit-serial equality checker: compares two WIDTH-bit operands received MSB first.
// Latency: done pulses WIDTH+1 cycles after start is sampled; back-to-back period WIDTH+1.
// Backpressure: none; start is only honoured in IDLE or DONE and ignored while shifting.
// Ports: clk, reset (async, active high), start, a_bit, b_bit in;
//        busy (shifting), done (1-cycle pulse), equal (held result), bit_count (pairs consumed) out.

module serial_equality_checker
   import serial_equality_checker_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         a_bit,
   input  logic                         b_bit,
   output logic                         busy,
   output logic                         done,
   output logic                         equal,
   output logic [$clog2(WIDTH+1)-1:0]   bit_count
);

   localparam int CW = $clog2(WIDTH+1);

   state_t state;
   state_t state_nxt;
   logic   match;
   logic   cell_match;
   logic   accept;
   logic   last_bit;

   equality_bit_cell u_cell (
      .a_bit     (a_bit),
      .b_bit     (b_bit),
      .match_in  (match),
      .match_out (cell_match)
   );

   // A new comparison may begin from IDLE or directly out of DONE.
   assign accept   = start && ((state == IDLE) || (state == DONE));
   assign last_bit = (state == SHIFT) && (bit_count == CW'(WIDTH - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = start ? SHIFT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // busy/done decode the state register only, so no input reaches an output combinationally.
   assign busy = (state == SHIFT);
   assign done = (state == DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         match     <= 1'b1;
         equal     <= 1'b0;
         bit_count <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            bit_count <= '0;
            match     <= 1'b1;
            equal     <= 1'b0;
         end else if (state == SHIFT) begin
            // Once cleared, match stays 0; all WIDTH bits are still consumed.
            match     <= cell_match;
            bit_count <= bit_count + CW'(1);
            if (last_bit) equal <= cell_match;
         end
      end
   end

endmodule

// File: tb/tb_serial_equality_checker.sv
module tb_serial_equality_checker;

   localparam int W  = 4;
   localparam int CW = $clog2(W + 1);

   logic          clk;
   logic          reset;
   logic          start;
   logic          a_bit;
   logic          b_bit;
   logic          busy;
   logic          done;
   logic          equal;
   logic [CW-1:0] bit_count;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   serial_equality_checker #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .a_bit     (a_bit),
      .b_bit     (b_bit),
      .busy      (busy),
      .done      (done),
      .equal     (equal),
      .bit_count (bit_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Quiet cycles with start low: outputs must stay settled.
   task automatic idle_check(input int n, input logic exp_equal, input int exp_cnt);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         chk1("idle_done", done, 1'b0);
         chk1("idle_busy", busy, 1'b0);
         chk1("idle_equal", equal, exp_equal);
         chkn("idle_count", 32'(bit_count), 32'(exp_cnt));
      end
   endtask

   // Reference: one comparison is a start cycle followed by W bit cycles, MSB first;
   // the result is simply whether the two operands are equal as numbers.
   // Called at posedge+1; returns at posedge+1 of the done cycle.
   task automatic compare(input logic [W-1:0] a, input logic [W-1:0] b, input bit chain,
                          input int pulse_bit, output int done_cyc);
      start = 1'b1;
      a_bit = 1'($urandom());
      b_bit = 1'($urandom());
      @(posedge clk); #1;
      chk1("accept_busy", busy, 1'b1);
      chk1("accept_done", done, 1'b0);
      chk1("accept_equal", equal, 1'b0);
      chkn("accept_count", 32'(bit_count), 32'd0);
      for (int i = 0; i < W; i++) begin
         a_bit = a[W-1-i];
         b_bit = b[W-1-i];
         start = (i == pulse_bit);
         @(posedge clk); #1;
         if (i < W - 1) begin
            chk1("shift_busy", busy, 1'b1);
            chk1("shift_done", done, 1'b0);
            chkn("shift_count", 32'(bit_count), 32'(i + 1));
         end else begin
            chk1("done_pulse", done, 1'b1);
            chk1("done_busy", busy, 1'b0);
            chk1("done_equal", equal, (a == b));
            chkn("done_count", 32'(bit_count), 32'(W));
            done_cyc = cyc;
         end
      end
      start = chain;
   endtask

   initial begin
      int d1;
      int d2;
      int prev_done;
      bit prev_chain;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      bit ch;

      reset = 1'b1;
      start = 1'b0;
      a_bit = 1'b0;
      b_bit = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk1("reset_busy", busy, 1'b0);
      chk1("reset_done", done, 1'b0);
      chk1("reset_equal", equal, 1'b0);
      chkn("reset_count", 32'(bit_count), 32'd0);
      reset = 1'b0;
      idle_check(10, 1'b0, 0);

      // Matching operands; result must be held afterwards.
      compare(4'b1011, 4'b1011, 1'b0, -1, d1);
      idle_check(3, 1'b1, W);

      // Mismatch on LSB only, then on MSB only.
      compare(4'b1011, 4'b1010, 1'b0, -1, d1);
      idle_check(1, 1'b0, W);
      compare(4'b0110, 4'b1110, 1'b0, -1, d1);
      idle_check(1, 1'b0, W);

      // Back-to-back: restart accepted in the DONE cycle.
      compare(4'b0000, 4'b0000, 1'b1, -1, d1);
      compare(4'b1111, 4'b0111, 1'b0, -1, d2);
      chkn("b2b_period", 32'(d2 - d1), 32'(W + 1));
      idle_check(1, 1'b0, W);

      // start pulsed during bit 2 is ignored; no second transfer follows.
      compare(4'b1100, 4'b1100, 1'b0, 2, d1);
      idle_check(4, 1'b1, W);

      // Asynchronous reset after two bits.
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a_bit = 1'b1; b_bit = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chkn("mid_count", 32'(bit_count), 32'd2);
      #2 reset = 1'b1;
      #1;
      chk1("async_busy", busy, 1'b0);
      chk1("async_done", done, 1'b0);
      chk1("async_equal", equal, 1'b0);
      chkn("async_count", 32'(bit_count), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      idle_check(2, 1'b0, 0);
      compare(4'b0101, 4'b0101, 1'b0, -1, d1);
      idle_check(1, 1'b1, W);

      // Randomized operands, about half forced equal, random chaining.
      prev_chain = 1'b0;
      prev_done  = 0;
      for (int n = 0; n < 30; n++) begin
         ra = W'($urandom());
         rb = ($urandom_range(0, 1) == 1) ? ra : W'($urandom());
         ch = (n == 29) ? 1'b0 : 1'($urandom_range(0, 1));
         compare(ra, rb, ch, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 2)) : -1, d1);
         if (prev_chain) chkn("rand_period", 32'(d1 - prev_done), 32'(W + 1));
         if (!ch) idle_check(1, (ra == rb), W);
         prev_chain = ch;
         prev_done  = d1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_equality_checker.md
Name: serial_equality_checker

Overview:
- Bit-serial counterpart of the team's parallel 4-bit gate-level equality comparator.
- Receives operands A and B one bit per clock, MSB first, and reports whether they were equal.
- Sits at the far end of a serial link that carries a nibble pair.
- Produces a one-cycle done pulse and a held equal flag using a small FSM and a bit counter.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..16.
- CW, $clog2(WIDTH+1), bit-counter width; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begins a comparison; sampled only in IDLE or DONE.
- a_bit  input  1  serial bit of A, MSB first.
- b_bit  input  1  serial bit of B, MSB first.
- busy  output  1  high while bits are being consumed (SHIFT).
- done  output  1  one-cycle pulse when the comparison completes.
- equal  output  1  result: 1 when all WIDTH bit pairs matched; held until the next accepted start.
- bit_count  output  CW  number of bit pairs consumed in the current comparison.

Behaviour:
- Reset (async, any state, including mid-comparison):
  - state=IDLE; busy=0, done=0, equal=0, bit_count=0.
  - Internal match accumulator cleared to 1.
  - Any partial comparison is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 → SHIFT next cycle; bit_count←0, match←1, equal←0.
  - a_bit/b_bit are ignored in the start cycle.
- SHIFT, each cycle:
  - match←match & ~(a_bit ^ b_bit).
  - bit_count←bit_count+1.
  - busy=1.
  - start is ignored.
  - When bit_count==WIDTH-1 in this cycle (last bit), go to DONE next cycle.
- DONE, exactly one cycle:
  - done=1; equal=final match; busy=0; bit_count=WIDTH.
  - start=1 in DONE is accepted: next state SHIFT, counter/match reinitialised, equal←0 from the next cycle.
  - start=0 → IDLE.
- Timing:
  - start sampled at edge 0.
  - Bits are sampled at edges 1..WIDTH.
  - done high in the cycle after edge WIDTH.
  - Back-to-back comparisons have a period of WIDTH+1 cycles.
- equal is registered and changes only on entry to DONE, on start acceptance (cleared), or on reset.
- A mismatch on any bit forces match=0 for the rest of the transfer. There is no early termination; all WIDTH bits are always consumed.
- bit_count saturates at WIDTH in DONE and resets to 0 on start acceptance. It never wraps.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package:
  - State enum (IDLE, SHIFT, DONE) as a 2-bit typedef.
  - Default WIDTH constant, shared with the parallel comparator.
- One natural sub-module: equality_bit_cell.
  - Computes the XNOR of a_bit/b_bit ANDed with the running match.
  - Built from the existing xnorgate and andgate primitives.
  - Instantiated once in the datapath.
- FSM, counter and output registers live in the top module.

Test Plan:
- Reset held, then released with no start → busy=0, done=0, equal=0, bit_count=0 for 10 cycles.
- start, then A=1011 / B=1011 serial MSB first → busy for 4 cycles; done=1 on cycle 5 with equal=1; equal stays 1 until the next start.
- start, then A=1011 / B=1010 (mismatch on LSB) → done on cycle 5 with equal=0. Repeat with a mismatch on the MSB only (A=0110 / B=1110) → equal=0.
- Back-to-back: start asserted in the DONE cycle after A=B=0000, then A=1111 / B=0111 → first done has equal=1. equal drops to 0 the cycle after the second start. Second done exactly 5 cycles after the first, with equal=0.
- start pulsed during SHIFT (bit 2) of a matching transfer → ignored; single done on cycle 5 with equal=1; no extra transfer follows.
- reset asserted asynchronously mid-SHIFT (after 2 bits) → outputs go to 0 immediately. A new start then comparing A=B=0101 completes with equal=1 after a full 4 bits.
